// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared definitions for the processor I/O bridge.
//   WORD_W      - data word width of the processor interface
//   irq_state_e - interrupt sequencer states
package io_bridge_pkg;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } irq_state_e;
endpackage

// File: rtl/io_fifo.sv
// io_fifo: first-word-fall-through FIFO, DEPTH entries of WORD_W bits.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and data (ignored when full unless a pop
//                happens in the same cycle)
//   pop        : consume head (ignored when empty)
//   dout       : head word, 0 when empty
//   empty, full, count : occupancy status
module io_fifo
  import io_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WORD_W-1:0]         din,
  output logic [WORD_W-1:0]         dout,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  // Storage is not cleared on reset; gating by empty hides stale words.
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;  // wraps modulo DEPTH (power of two)
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/proc_io_bridge.sv
// proc_io_bridge: I/O responder beside the 16-bit MIPS core.
//   clk, reset                 : clock, synchronous active-high reset
//   cpu_data_out, cpu_out_we   : processor writes -> TX FIFO
//   cpu_in_re, cpu_data_in     : processor reads RX FIFO head (0 when empty)
//   interrupt                  : one-cycle pulse when RX data is waiting
//   ext_rx_data/valid/ready    : external source -> RX FIFO
//   ext_tx_data/valid/ready    : TX FIFO -> external sink
//   tx_overflow, rx_underflow  : sticky error flags, cleared by reset only
//   rx_count, tx_count         : FIFO occupancy
module proc_io_bridge
  import io_bridge_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            cpu_data_out,
  input  logic                   cpu_out_we,
  input  logic                   cpu_in_re,
  output logic [15:0]            cpu_data_in,
  output logic                   interrupt,
  input  logic [15:0]            ext_rx_data,
  input  logic                   ext_rx_valid,
  output logic                   ext_rx_ready,
  output logic [15:0]            ext_tx_data,
  output logic                   ext_tx_valid,
  input  logic                   ext_tx_ready,
  output logic                   tx_overflow,
  output logic                   rx_underflow,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic [$clog2(DEPTH):0] tx_count
);
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_pop, rx_push;

  assign ext_tx_valid = ~tx_empty;
  assign tx_pop       = ext_tx_valid & ext_tx_ready;
  // Ready depends on registered occupancy only; no same-cycle pop bypass.
  assign ext_rx_ready = ~rx_full;
  assign rx_push      = ext_rx_valid & ext_rx_ready;

  io_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cpu_out_we),
    .pop   (tx_pop),
    .din   (cpu_data_out),
    .dout  (ext_tx_data),
    .empty (tx_empty),
    .full  (tx_full),
    .count (tx_count)
  );

  io_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (cpu_in_re),
    .din   (ext_rx_data),
    .dout  (cpu_data_in),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count)
  );

  // Sticky error flags.
  logic tx_overflow_q, tx_overflow_d;
  logic rx_underflow_q, rx_underflow_d;

  always_comb begin
    tx_overflow_d  = tx_overflow_q  | (cpu_out_we & tx_full & ~tx_pop);
    rx_underflow_d = rx_underflow_q | (cpu_in_re & rx_empty);
  end

  assign tx_overflow  = tx_overflow_q;
  assign rx_underflow = rx_underflow_q;

  // Interrupt sequencer: fire once, wait for the CPU to read, then hold
  // off HOLDOFF cycles before another pulse may be raised.
  irq_state_e    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          interrupt_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: if (!rx_empty) state_d = FIRE;
      // A read already in the pulse cycle counts as the acknowledge.
      FIRE: begin
        if (cpu_in_re) begin
          state_d    = HOLD;
          hold_cnt_d = HW'(HOLDOFF - 1);
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cpu_in_re) begin
          state_d    = HOLD;
          hold_cnt_d = HW'(HOLDOFF - 1);
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) state_d = IDLE;
        else                  hold_cnt_d = hold_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      hold_cnt_q     <= '0;
      interrupt_q    <= 1'b0;
      tx_overflow_q  <= 1'b0;
      rx_underflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      interrupt_q    <= (state_d == FIRE);
      tx_overflow_q  <= tx_overflow_d;
      rx_underflow_q <= rx_underflow_d;
    end
  end

  assign interrupt = interrupt_q;
endmodule

// File: doc/proc_io_bridge.md
Name: proc_io_bridge

Overview:
- Processor-facing I/O responder for the 16-bit MIPS core.
- Consumes the core's `data_out` writes into a TX FIFO and drains them to an external valid/ready sink.
- Accepts words from an external valid/ready source into an RX FIFO, presents the head word on the core's `data_in`, and raises the core's `interrupt` input when RX data arrives.
- Sits beside the processor top as the other end of its `data_in`/`data_out`/`interrupt` interface.

Parameters:
- DEPTH, 4, entries per FIFO; power of two, at least 2.
- HOLDOFF, 8, cycles after a CPU read before `interrupt` may re-fire.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_data_out  in  16  word written by the processor.
- cpu_out_we  in  1  processor output strobe; push `cpu_data_out` to TX FIFO.
- cpu_in_re  in  1  processor consumed `cpu_data_in`; pop RX FIFO.
- cpu_data_in  out  16  RX FIFO head; 16'h0000 when RX is empty.
- interrupt  out  1  one-cycle interrupt pulse to the processor.
- ext_rx_data  in  16  external source data.
- ext_rx_valid  in  1  external source valid.
- ext_rx_ready  out  1  RX FIFO can accept.
- ext_tx_data  out  16  TX FIFO head.
- ext_tx_valid  out  1  TX FIFO non-empty.
- ext_tx_ready  in  1  external sink ready.
- tx_overflow  out  1  sticky: a CPU write was dropped.
- rx_underflow  out  1  sticky: a CPU read hit an empty RX FIFO.
- rx_count  out  $clog2(DEPTH)+1  RX occupancy.
- tx_count  out  $clog2(DEPTH)+1  TX occupancy.

Behaviour:
- Reset: one clock, synchronous, active-high. Both FIFOs empty, pointers 0, counts 0, sticky flags 0, `interrupt`=0, FSM=IDLE, holdoff counter 0.
- Reset mid-transfer discards FIFO contents; stale storage is never visible because outputs are gated by empty.
- Reset values of outputs:
  - `cpu_data_in`=0, `ext_tx_data`=0.
  - `ext_tx_valid`=0, `ext_rx_ready`=1.
- FIFOs are first-word-fall-through.
  - Head is driven combinationally from registered storage.
  - Occupancy updates on the clock edge; a pushed word is visible at the head the cycle after the push.
- TX push:
  - Occurs when `cpu_out_we`=1 and (not full, or `ext_tx_valid & ext_tx_ready` in the same cycle).
  - Otherwise the word is dropped and `tx_overflow` is set.
  - A push and a pop in the same cycle leave `tx_count` unchanged.
- TX pop: `ext_tx_valid & ext_tx_ready`; `ext_tx_valid` = !tx_empty.
- RX push:
  - `ext_rx_ready` = !rx_full, registered-state only, with no same-cycle pop bypass.
  - Transfer occurs on `ext_rx_valid & ext_rx_ready`.
- RX pop:
  - `cpu_in_re` while non-empty.
  - `cpu_in_re` while empty has no effect on pointers and sets `rx_underflow`.
  - A push in that same cycle still proceeds.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Count is the full/empty source: full when count==DEPTH.
- Sticky flags clear only on reset.
- Interrupt FSM:
  - IDLE: if rx_count!=0 → FIRE.
  - FIRE: `interrupt`=1 for exactly one cycle → WAIT.
  - WAIT: on `cpu_in_re` → HOLD; load the counter with HOLDOFF-1.
  - HOLD: decrement each cycle; at 0 → IDLE. IDLE then re-fires if RX is still non-empty.
- `interrupt` is registered: it is high in the cycle the FSM is in FIRE, and never high in two consecutive cycles.
- A `cpu_in_re` in FIRE is honoured as the WAIT exit: FIRE → HOLD.

Decomposition:
- Shared package `io_bridge_pkg`:
  - WORD_W=16.
  - FSM state enum: IDLE=2'd0, FIRE=2'd1, WAIT=2'd2, HOLD=2'd3.
- One sub-module: `io_fifo`, parameterised by DEPTH.
  - Inputs: push, pop, din.
  - Outputs: dout, empty, full, count.
  - Push-when-full and pop-when-empty are ignored internally; they are flagged in the parent.
  - The FIFO is instantiated twice, once for RX and once for TX.

Test Plan:
- Reset, then idle for 5 cycles → `ext_tx_valid`=0, `ext_rx_ready`=1, `cpu_data_in`=0, `interrupt`=0, counts=0.
- CPU writes 16'h1111, 16'h2222, 16'h3333 with `ext_tx_ready`=0 → `tx_count`=3. Raise ready → `ext_tx_data` sequence 1111, 2222, 3333, then `ext_tx_valid`=0.
- 5 CPU writes with DEPTH=4 and sink stalled → 5th dropped, `tx_overflow`=1, `tx_count`=4. Write with simultaneous sink pop while full → accepted, count stays 4.
- External source pushes 16'hABCD → `interrupt` pulse exactly one cycle, 2 cycles after transfer, and `cpu_data_in`=ABCD.
- With 2 RX words present, CPU reads the first → no interrupt for HOLDOFF=8 cycles, then a second one-cycle pulse.
- `cpu_in_re` with RX empty → `rx_underflow`=1, `rx_count` stays 0. Assert reset mid-stream with 3 words queued → all counts 0 and flags cleared next cycle.
